// File: rtl/sipo_frame_collector.sv
// sipo_frame_collector
// Assembles a serial bit stream into WIDTH-bit frames (MSB- or LSB-first)
// and presents each completed word through a one-entry valid/ready buffer.
// A word completed while the buffer is full and not draining is dropped
// and latched into a sticky overrun flag.
module sipo_frame_collector #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       d,
    input  logic                       d_valid,
    input  logic                       start,
    output logic [WIDTH-1:0]           pdata,
    output logic                       pvalid,
    input  logic                       pready,
    output logic                       busy,
    output logic [$clog2(WIDTH):0]     bit_cnt,
    output logic                       overrun,
    input  logic                       clr_ovr
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sreg_r;
    logic [WIDTH-1:0] sreg_nxt_s;
    logic [WIDTH-1:0] shift_in_s;
    logic [WIDTH-1:0] first_bit_s;
    logic [CW-1:0]    cnt_r;
    logic [CW-1:0]    cnt_nxt_s;
    logic             done_s;
    logic             load_s;
    logic             drop_s;
    logic [WIDTH-1:0] pdata_r;
    logic             pvalid_r;
    logic             busy_r;
    logic             ovr_r;

    // Shift network: shifted register with d inserted, and a fresh frame holding only bit 0.
    always_comb begin
        shift_in_s  = '0;
        first_bit_s = '0;
        if (MSB_FIRST) begin
            shift_in_s  = {sreg_r[WIDTH-2:0], d};
            first_bit_s = {{(WIDTH-1){1'b0}}, d};
        end else begin
            shift_in_s  = {d, sreg_r[WIDTH-1:1]};
            first_bit_s = {d, {(WIDTH-1){1'b0}}};
        end
    end

    // Collector FSM next state: frame start, shift, resync and completion.
    always_comb begin
        state_nxt_s = state_r;
        sreg_nxt_s  = sreg_r;
        cnt_nxt_s   = cnt_r;
        done_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (d_valid && start) begin
                    sreg_nxt_s  = first_bit_s;
                    cnt_nxt_s   = ONE_CNT;
                    state_nxt_s = SHIFT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SHIFT: begin
                if (d_valid) begin
                    if (cnt_r == LAST_CNT) begin
                        // The completing bit ends the frame even if start is raised with it.
                        done_s      = 1'b1;
                        sreg_nxt_s  = '0;
                        cnt_nxt_s   = '0;
                        state_nxt_s = IDLE;
                    end else if (start) begin
                        sreg_nxt_s  = first_bit_s;
                        cnt_nxt_s   = ONE_CNT;
                        state_nxt_s = SHIFT;
                    end else begin
                        sreg_nxt_s  = shift_in_s;
                        cnt_nxt_s   = cnt_r + ONE_CNT;
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = SHIFT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                sreg_nxt_s  = '0;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // Output buffer decisions: load when empty or draining this edge, else drop.
    always_comb begin
        load_s = 1'b0;
        drop_s = 1'b0;
        if (done_s) begin
            if (!pvalid_r || pready) begin
                load_s = 1'b1;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
            drop_s = 1'b0;
        end
    end

    // Collector state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            sreg_r  <= '0;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            sreg_r  <= sreg_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == SHIFT);
        end
    end

    // Output word buffer and sticky overrun; a new overrun beats clr_ovr.
    always_ff @(posedge clk) begin
        if (rst) begin
            pdata_r  <= '0;
            pvalid_r <= 1'b0;
            ovr_r    <= 1'b0;
        end else begin
            if (load_s) begin
                pdata_r  <= shift_in_s;
                pvalid_r <= 1'b1;
            end else if (pvalid_r && pready) begin
                pvalid_r <= 1'b0;
            end
            if (drop_s) begin
                ovr_r <= 1'b1;
            end else if (clr_ovr) begin
                ovr_r <= 1'b0;
            end
        end
    end

    assign pdata   = pdata_r;
    assign pvalid  = pvalid_r;
    assign busy    = busy_r;
    assign bit_cnt = cnt_r;
    assign overrun = ovr_r;

endmodule

// File: tb/tb_sipo_frame_collector.sv
// Bench for sipo_frame_collector: an MSB-first and an LSB-first instance
// share one stimulus stream; a bit-list reference model predicts both.
module tb_sipo_frame_collector;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst, d, d_valid, start, pready, clr_ovr;

    logic [W-1:0] pdata_m, pdata_l;
    logic         pvalid_m, pvalid_l, busy_m, busy_l, ovr_m, ovr_l;
    logic [3:0]   cnt_m, cnt_l;

    int total = 0;
    int bad   = 0;
    int pv_rises = 0;
    logic pv_prev = 1'b0;

    // reference model state
    logic         mbits[$];
    logic         m_in;
    logic         m_pv;
    logic [W-1:0] m_pdm, m_pdl;
    logic         m_ovr;

    always #5 clk = ~clk;

    sipo_frame_collector #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .start(start),
        .pdata(pdata_m), .pvalid(pvalid_m), .pready(pready), .busy(busy_m),
        .bit_cnt(cnt_m), .overrun(ovr_m), .clr_ovr(clr_ovr));

    sipo_frame_collector #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .start(start),
        .pdata(pdata_l), .pvalid(pvalid_l), .pready(pready), .busy(busy_l),
        .bit_cnt(cnt_l), .overrun(ovr_l), .clr_ovr(clr_ovr));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: one rising edge with the currently applied inputs.
    task automatic model_edge();
        logic         done;
        logic [W-1:0] wm, wl;
        done = 1'b0;
        wm = '0;
        wl = '0;
        if (rst) begin
            mbits.delete();
            m_in = 1'b0; m_pv = 1'b0; m_pdm = '0; m_pdl = '0; m_ovr = 1'b0;
        end else begin
            if (d_valid) begin
                if (!m_in) begin
                    if (start) begin
                        mbits.delete();
                        mbits.push_back(d);
                        m_in = 1'b1;
                    end
                end else if (mbits.size() == W - 1) begin
                    mbits.push_back(d);
                    for (int i = 0; i < W; i++) begin
                        wm = wm | (W'(mbits[i]) << (W - 1 - i));
                        wl = wl | (W'(mbits[i]) << i);
                    end
                    done = 1'b1;
                    mbits.delete();
                    m_in = 1'b0;
                end else if (start) begin
                    mbits.delete();
                    mbits.push_back(d);
                end else begin
                    mbits.push_back(d);
                end
            end
            if (done && m_pv && !pready) begin
                m_ovr = 1'b1;
            end else begin
                if (clr_ovr) m_ovr = 1'b0;
                if (done) begin
                    m_pv = 1'b1; m_pdm = wm; m_pdl = wl;
                end else if (m_pv && pready) begin
                    m_pv = 1'b0;
                end
            end
        end
    endtask

    task automatic step(input logic i_d, input logic i_dv, input logic i_st,
                        input logic i_pr, input logic i_clr, input logic i_rst);
        d = i_d; d_valid = i_dv; start = i_st; pready = i_pr; clr_ovr = i_clr; rst = i_rst;
        @(posedge clk);
        model_edge();
        #1;
        if (pvalid_m && !pv_prev) pv_rises++;
        pv_prev = pvalid_m;
        chk("pdata_msb",   32'(pdata_m),  32'(m_pdm));
        chk("pdata_lsb",   32'(pdata_l),  32'(m_pdl));
        chk("pvalid_msb",  32'(pvalid_m), 32'(m_pv));
        chk("pvalid_lsb",  32'(pvalid_l), 32'(m_pv));
        chk("busy_msb",    32'(busy_m),   32'(m_in));
        chk("busy_lsb",    32'(busy_l),   32'(m_in));
        chk("bitcnt_msb",  32'(cnt_m),    32'(mbits.size()));
        chk("bitcnt_lsb",  32'(cnt_l),    32'(mbits.size()));
        chk("overrun_msb", 32'(ovr_m),    32'(m_ovr));
        chk("overrun_lsb", 32'(ovr_l),    32'(m_ovr));
    endtask

    // Send word w MSB-bit first, start on bit 0, gap idle cycles between bits.
    task automatic frame(input logic [W-1:0] w, input int gap, input logic pr,
                         input logic pr_last, input logic clr_last);
        for (int i = 0; i < W; i++) begin
            step(w[W-1-i], 1'b1, (i == 0), (i == W - 1) ? pr_last : pr,
                 (i == W - 1) ? clr_last : 1'b0, 1'b0);
            if (i < W - 1) begin
                for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, pr, 1'b0, 1'b0);
            end
        end
    endtask

    initial begin
        m_in = 1'b0; m_pv = 1'b0; m_pdm = '0; m_pdl = '0; m_ovr = 1'b0;
        d = 1'b0; d_valid = 1'b0; start = 1'b0; pready = 1'b0; clr_ovr = 1'b0; rst = 1'b1;

        // reset state
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("reset_pvalid", 32'(pvalid_m), 32'd0);
        chk("reset_cnt",    32'(cnt_l),    32'd0);

        // MSB-first / LSB-first consecutive bits
        frame(8'hB2, 0, 1'b1, 1'b1, 1'b0);
        chk("plan_msb_B2",   32'(pdata_m),  32'h000000B2);
        chk("plan_lsb_4D",   32'(pdata_l),  32'h0000004D);
        chk("plan_pvalid",   32'(pvalid_m), 32'd1);
        chk("plan_busy_low", 32'(busy_m),   32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // gaps between bits
        frame(8'hB2, 2, 1'b1, 1'b1, 1'b0);
        chk("gap_lsb_4D", 32'(pdata_l), 32'h0000004D);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // backpressure, overrun set wins over clr_ovr on the same edge
        frame(8'hA5, 0, 1'b0, 1'b0, 1'b0);
        frame(8'h3C, 0, 1'b0, 1'b0, 1'b1);
        chk("bp_hold_A5", 32'(pdata_m), 32'h000000A5);
        chk("bp_overrun", 32'(ovr_m),   32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bp_drained", 32'(pvalid_m), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_clr_ovr", 32'(ovr_m), 32'd0);

        // simultaneous drain and load
        frame(8'h11, 0, 1'b0, 1'b0, 1'b0);
        frame(8'h22, 0, 1'b0, 1'b1, 1'b0);
        chk("dl_pvalid", 32'(pvalid_m), 32'd1);
        chk("dl_pdata",  32'(pdata_m),  32'h00000022);
        chk("dl_ovr",    32'(ovr_m),    32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // resync after a partial frame
        pv_rises = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, (i == 0), 1'b1, 1'b0, 1'b0);
        frame(8'hFF, 0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("rs_pdata", 32'(pdata_m), 32'h000000FF);
        chk("rs_ovr",   32'(ovr_m),   32'd0);
        chk("rs_pulses", 32'(pv_rises), 32'd1);

        // reset mid-frame
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, (i == 0), 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("mr_pdata", 32'(pdata_m), 32'd0);
        chk("mr_busy",  32'(busy_m),  32'd0);
        chk("mr_cnt",   32'(cnt_m),   32'd0);
        frame(8'h81, 0, 1'b0, 1'b0, 1'b0);
        chk("mr_81", 32'(pdata_m), 32'h00000081);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 2) != 0),
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 299) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
